ntt_bank_map_k2: RTL and testbench
==================================

# ntt_bank_map_k2

Address-mapping and write-back scheduling stage directly downstream of the k2 address generator in the NTT datapath. It consumes each butterfly's index pair (Order_0, Order_1) with its valid and done strobes. It maps each index to a conflict-free memory bank and in-bank address, and issues registered dual-bank read requests. It then replays the same addresses as write requests after the butterfly latency, and signals stage completion once the pipeline has drained.

## Interface
- D_WIDTH, `D_width`: index width, matching the generator outputs.
- BF_LAT, 4: butterfly datapath latency in cycles, from read data valid to result valid; legal range 1..15.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous clear of all pipeline state
- in_valid  in  1  index pair valid (generator out-enable)
- in_done  in  1  one-cycle generator completion strobe
- order_0  in  D_WIDTH  first butterfly index
- order_1  in  D_WIDTH  second butterfly index
- rd_en  out  1  read request to both banks
- rd_addr_b0  out  D_WIDTH-1  bank-0 address
- rd_addr_b1  out  D_WIDTH-1  bank-1 address
- rd_swap  out  1  1 means order_0 lives in bank 1
- wr_en  out  1  write-back request to both banks
- wr_addr_b0  out  D_WIDTH-1  bank-0 write address
- wr_addr_b1  out  D_WIDTH-1  bank-1 write address
- wr_swap  out  1  swap flag matching wr_addr
- map_done  out  1  one-cycle pulse when the stage is fully written back

## Operation
- Bank mapping:
  - bank(x) = XOR-reduction of all D_WIDTH bits of x.
  - addr(x) = x >> 1.
  - order_0 and order_1 differ only in bit 0, so they always map to opposite banks.
- Swap: swap = bank(order_0).
  - swap=0: b0 takes addr(order_0) and b1 takes addr(order_1).
  - swap=1: the assignment is reversed.
- Read stage: registers {rd_en, rd_addr_b0, rd_addr_b1, rd_swap} from the mapped input each cycle. When in_valid=0, rd_en=0 and the address outputs hold their previous values.
- Write-back delay line: BF_LAT-entry shift register of {valid, addr_b0, addr_b1, swap}, fed from the read-stage registers. The tail drives wr_*. Bubbles propagate unchanged; there is no back-pressure.
- Outstanding counter, width clog2(BF_LAT+2):
  - +1 on in_valid and -1 on wr_en.
  - Both in the same cycle leave it unchanged.
- Drain control, states IDLE, RUN, DRAIN:
  - IDLE to RUN on in_valid.
  - RUN to DRAIN on in_done.
  - In DRAIN, when outstanding==0 and in_valid=0: pulse map_done, then go to IDLE.
  - in_done in IDLE is handled like in_done in RUN (the empty-stage case).
  - in_valid together with in_done counts that pair before draining.
- flush: clears the delay line, counter, state and all outputs to 0 in the next cycle. It has priority over every other input.
- Counter overflow cannot occur by construction (at most BF_LAT+1 pairs in flight).

## Timing
- Reset values: every output 0, state IDLE, delay line empty.
- in_valid at edge t gives rd_en at t+1 and wr_en at t+1+BF_LAT.
- map_done occurs no earlier than one cycle after the final wr_en.
- If in_done arrives with nothing outstanding, map_done pulses at t+1.
- rst asserted mid-stream aborts everything immediately. No map_done is generated for the aborted stage.

## Configuration
- NTT_BANK_MAP_CHK_EN defined:
  - Adds output conflict_err (1 bit, sticky until rst/flush).
  - It sets when an accepted pair maps to the same bank, or when order_1 != order_0+1.
- Macro undefined: the port and its logic are absent, with no other behavioural change.

## Structure
- Shared package:
  - Read/write request struct typedef {valid, addr_b0, addr_b1, swap}.
  - Drain-FSM state enum.
  - bank_of() and addr_of() functions.
- One sub-module: ntt_delay_line, a parameterised depth/width shift register with synchronous clear, used for the write-back path.

## Test plan
- Orders 6,7 valid at t: rd_en at t+1 with b0=3, b1=3, swap=0. Same values appear on wr_* at t+5 (BF_LAT=4).
- Orders 2,3: b0=1, b1=1, swap=1.
- 8 back-to-back pairs then in_done with the last pair: 8 consecutive wr_en, then map_done exactly one cycle after the 8th wr_en.
- in_valid toggling 1,0,1: rd_en and wr_en reproduce the same gap pattern; the outstanding count returns to 0.
- flush while 3 pairs are in flight: no further wr_en and no map_done; the next stage runs normally.
- Build with NTT_BANK_MAP_CHK_EN and drive orders 4,6: conflict_err rises at t+1 and stays high until flush.

Source files
------------

// File: rtl/ntt_bank_map_k2_pkg.sv
// Shared types and bank-mapping helpers for the k2 NTT bank-map stage.
package ntt_bank_map_k2_pkg;

    localparam int unsigned NTT_D_WIDTH = 8;
    localparam int unsigned NTT_A_WIDTH = NTT_D_WIDTH - 1;

    typedef struct packed {
        logic                   valid;
        logic [NTT_A_WIDTH-1:0] addr_b0;
        logic [NTT_A_WIDTH-1:0] addr_b1;
        logic                   swap;
    } bank_req_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } drain_state_t;

    // Parity of the index selects the bank, so neighbours land in opposite banks.
    function automatic logic bank_of(input logic [NTT_D_WIDTH-1:0] x);
        return ^x;
    endfunction

    function automatic logic [NTT_A_WIDTH-1:0] addr_of(input logic [NTT_D_WIDTH-1:0] x);
        return NTT_A_WIDTH'(x >> 1);
    endfunction

endpackage

// File: rtl/ntt_delay_line.sv
// Fixed-depth shift register with synchronous clear; carries write-back requests.
module ntt_delay_line #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/ntt_bank_map_k2.sv
// Bank mapping, read issue, delayed write-back replay and drain detection for k2 NTT.
// Optional NTT_BANK_MAP_CHK_EN adds a sticky conflict_err output.
module ntt_bank_map_k2
    import ntt_bank_map_k2_pkg::*;
#(
    parameter int unsigned D_WIDTH = NTT_D_WIDTH,
    parameter int unsigned BF_LAT  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    input  logic               in_done,
    input  logic [D_WIDTH-1:0] order_0,
    input  logic [D_WIDTH-1:0] order_1,
    output logic               rd_en,
    output logic [D_WIDTH-2:0] rd_addr_b0,
    output logic [D_WIDTH-2:0] rd_addr_b1,
    output logic               rd_swap,
    output logic               wr_en,
    output logic [D_WIDTH-2:0] wr_addr_b0,
    output logic [D_WIDTH-2:0] wr_addr_b1,
    output logic               wr_swap,
    output logic               map_done
`ifdef NTT_BANK_MAP_CHK_EN
    ,
    output logic               conflict_err
`endif
);

    localparam int unsigned CNT_W = $clog2(BF_LAT + 2);

    bank_req_t            rd_q, rd_d;
    bank_req_t            wr_req;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    drain_state_t         state_q, state_d;
    logic                 map_done_q, map_done_d;
    logic                 swap_c;
    logic                 finish_c;

    // Read request: addresses hold while no pair is presented.
    always_comb begin
        swap_c = bank_of(order_0);
        rd_d   = rd_q;
        rd_d.valid = in_valid;
        if (in_valid) begin
            rd_d.swap    = swap_c;
            rd_d.addr_b0 = swap_c ? addr_of(order_1) : addr_of(order_0);
            rd_d.addr_b1 = swap_c ? addr_of(order_0) : addr_of(order_1);
        end
        if (flush) begin
            rd_d = '0;
        end
    end

    ntt_delay_line #(
        .DEPTH (BF_LAT),
        .WIDTH ($bits(bank_req_t))
    ) u_wb_line (
        .clk  (clk),
        .rst  (rst),
        .clr  (flush),
        .din  (rd_q),
        .dout (wr_req)
    );

    // Drain FSM; completion looks at the post-update count so map_done follows the last write by one cycle.
    always_comb begin
        state_d    = state_q;
        map_done_d = 1'b0;
        cnt_d      = cnt_q + CNT_W'(in_valid) - CNT_W'(wr_req.valid);
        finish_c   = ((state_q == ST_DRAIN) || in_done) && (cnt_d == '0) && !in_valid;
        case (state_q)
            ST_IDLE: begin
                if (in_done) begin
                    state_d = ST_DRAIN;
                end else if (in_valid) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (in_done) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DRAIN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (finish_c) begin
            state_d    = ST_IDLE;
            map_done_d = 1'b1;
        end
        if (flush) begin
            state_d    = ST_IDLE;
            map_done_d = 1'b0;
            cnt_d      = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q       <= '0;
            cnt_q      <= '0;
            state_q    <= ST_IDLE;
            map_done_q <= 1'b0;
        end else begin
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            map_done_q <= map_done_d;
        end
    end

    assign rd_en      = rd_q.valid;
    assign rd_addr_b0 = rd_q.addr_b0;
    assign rd_addr_b1 = rd_q.addr_b1;
    assign rd_swap    = rd_q.swap;
    assign wr_en      = wr_req.valid;
    assign wr_addr_b0 = wr_req.addr_b0;
    assign wr_addr_b1 = wr_req.addr_b1;
    assign wr_swap    = wr_req.swap;
    assign map_done   = map_done_q;

`ifdef NTT_BANK_MAP_CHK_EN
    logic conflict_err_q, conflict_err_d;

    // Sticky flag for pairs that break the adjacent-index assumption.
    always_comb begin
        conflict_err_d = conflict_err_q;
        if (in_valid && ((bank_of(order_0) == bank_of(order_1)) ||
                         (order_1 != order_0 + D_WIDTH'(1)))) begin
            conflict_err_d = 1'b1;
        end
        if (flush) begin
            conflict_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_err_q <= 1'b0;
        end else begin
            conflict_err_q <= conflict_err_d;
        end
    end

    assign conflict_err = conflict_err_q;
`endif

endmodule

// File: tb/tb_ntt_bank_map_k2.sv
// Self-checking bench for ntt_bank_map_k2: directed vector table, corner sequences, random vs. model.
module tb_ntt_bank_map_k2;

    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = DW - 1;
    localparam int unsigned LAT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_done = 1'b0;
    logic [DW-1:0] order_0 = '0;
    logic [DW-1:0] order_1 = '0;
    logic          rd_en, wr_en, rd_swap, wr_swap, map_done;
    logic [AW-1:0] rd_addr_b0, rd_addr_b1, wr_addr_b0, wr_addr_b1;
`ifdef NTT_BANK_MAP_CHK_EN
    logic          conflict_err;
`endif

    ntt_bank_map_k2 #(.D_WIDTH(DW), .BF_LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_done    (in_done),
        .order_0    (order_0),
        .order_1    (order_1),
        .rd_en      (rd_en),
        .rd_addr_b0 (rd_addr_b0),
        .rd_addr_b1 (rd_addr_b1),
        .rd_swap    (rd_swap),
        .wr_en      (wr_en),
        .wr_addr_b0 (wr_addr_b0),
        .wr_addr_b1 (wr_addr_b1),
        .wr_swap    (wr_swap),
        .map_done   (map_done)
`ifdef NTT_BANK_MAP_CHK_EN
        ,
        .conflict_err (conflict_err)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: each accepted pair is written exactly LAT samples after it is read.
    typedef struct {
        int       t;
        int       b0;
        int       b1;
        int       sw;
    } wr_t;

    wr_t wq[$];
    int  k;
    int  last_wr;
    bit  draining;
    bit  err_m;
    int  e_rd_en, e_rd_b0, e_rd_b1, e_rd_sw;
    int  e_wr_en, e_wr_b0, e_wr_b1, e_wr_sw;
    int  e_done;

    function automatic int bank_m(input logic [DW-1:0] x);
        return $countones(x) % 2;
    endfunction

    task automatic model_reset();
        wq.delete();
        last_wr  = -1000;
        draining = 0;
        err_m    = 0;
        e_rd_en = 0; e_rd_b0 = 0; e_rd_b1 = 0; e_rd_sw = 0;
        e_wr_en = 0; e_wr_b0 = 0; e_wr_b1 = 0; e_wr_sw = 0;
        e_done  = 0;
    endtask

    task automatic model_step(input bit v, input bit d, input bit fl,
                              input logic [DW-1:0] o0, input logic [DW-1:0] o1);
        wr_t w;
        int  a0, a1;
        k++;
        if (fl) begin
            model_reset();
            return;
        end
        e_wr_en = 0;
        if (wq.size() > 0 && wq[0].t == k) begin
            w = wq.pop_front();
            e_wr_en = 1; e_wr_b0 = w.b0; e_wr_b1 = w.b1; e_wr_sw = w.sw;
        end
        e_rd_en = v;
        if (v) begin
            a0 = int'(o0) / 2;
            a1 = int'(o1) / 2;
            e_rd_sw = bank_m(o0);
            e_rd_b0 = (e_rd_sw != 0) ? a1 : a0;
            e_rd_b1 = (e_rd_sw != 0) ? a0 : a1;
            w.t = k + LAT; w.b0 = e_rd_b0; w.b1 = e_rd_b1; w.sw = e_rd_sw;
            wq.push_back(w);
            last_wr = k + LAT;
            if (bank_m(o0) == bank_m(o1) || o1 != DW'(o0 + 1)) err_m = 1;
        end
        if (d) draining = 1;
        e_done = (draining && !v && last_wr < k) ? 1 : 0;
        if (e_done != 0) draining = 0;
    endtask

    task automatic compare_all();
        check("rd_en", int'(rd_en), e_rd_en);
        check("rd_addr_b0", int'(rd_addr_b0), e_rd_b0);
        check("rd_addr_b1", int'(rd_addr_b1), e_rd_b1);
        check("rd_swap", int'(rd_swap), e_rd_sw);
        check("wr_en", int'(wr_en), e_wr_en);
        if (e_wr_en != 0) begin
            check("wr_addr_b0", int'(wr_addr_b0), e_wr_b0);
            check("wr_addr_b1", int'(wr_addr_b1), e_wr_b1);
            check("wr_swap", int'(wr_swap), e_wr_sw);
        end
        check("map_done", int'(map_done), e_done);
`ifdef NTT_BANK_MAP_CHK_EN
        check("conflict_err", int'(conflict_err), int'(err_m));
`endif
    endtask

    task automatic step(input bit v, input bit d, input bit fl,
                        input logic [DW-1:0] o0, input logic [DW-1:0] o1);
        in_valid = v; in_done = d; flush = fl; order_0 = o0; order_1 = o1;
        @(posedge clk);
        #1;
        model_step(v, d, fl, o0, o1);
        compare_all();
        in_valid = 0; in_done = 0; flush = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0);
    endtask

    typedef struct {
        bit            v;
        logic [DW-1:0] o0;
        logic [DW-1:0] o1;
        bit            e_en;
        int            e_b0;
        int            e_b1;
        int            e_sw;
    } vec_t;

    vec_t vecs[8];
    int   wr_seen, last_wr_at, done_at, done_cnt;
    logic [DW-1:0] r0, r1;

    initial begin
        vecs[0] = '{1, 8'd6,   8'd7,   1, 3,   3,   0};
        vecs[1] = '{1, 8'd2,   8'd3,   1, 1,   1,   1};
        vecs[2] = '{0, 8'd0,   8'd0,   0, 1,   1,   1};
        vecs[3] = '{1, 8'd4,   8'd6,   1, 3,   2,   1};
        vecs[4] = '{1, 8'hFE,  8'hFF,  1, 127, 127, 1};
        vecs[5] = '{1, 8'h0C,  8'h0D,  1, 6,   6,   0};
        vecs[6] = '{0, 8'h55,  8'h56,  0, 6,   6,   0};
        vecs[7] = '{1, 8'h10,  8'h11,  1, 8,   8,   1};

        k = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_rd_en", int'(rd_en), 0);
        check("reset_wr_en", int'(wr_en), 0);
        check("reset_map_done", int'(map_done), 0);
        check("reset_rd_addr_b0", int'(rd_addr_b0), 0);
        rst = 0;

        // Directed read-mapping vectors; write-back replay is checked by the model.
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].v, 0, 0, vecs[i].o0, vecs[i].o1);
            check("vec_rd_en", int'(rd_en), int'(vecs[i].e_en));
            check("vec_rd_b0", int'(rd_addr_b0), vecs[i].e_b0);
            check("vec_rd_b1", int'(rd_addr_b1), vecs[i].e_b1);
            check("vec_rd_swap", int'(rd_swap), vecs[i].e_sw);
        end
`ifdef NTT_BANK_MAP_CHK_EN
        check("conflict_sticky", int'(conflict_err), 1);
`endif
        step(0, 1, 0, '0, '0);
        idle(LAT + 3);
        step(0, 0, 1, '0, '0);
`ifdef NTT_BANK_MAP_CHK_EN
        check("conflict_cleared", int'(conflict_err), 0);
`endif

        // Eight back-to-back pairs, in_done with the last one.
        wr_seen = 0; last_wr_at = -1; done_at = -1; done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, (i == 7), 0, DW'(2 * i), DW'(2 * i + 1));
            if (wr_en) begin wr_seen++; last_wr_at = k; end
            if (map_done) begin done_cnt++; done_at = k; end
        end
        for (int i = 0; i < 3 * LAT + 4; i++) begin
            step(0, 0, 0, '0, '0);
            if (wr_en) begin wr_seen++; last_wr_at = k; end
            if (map_done) begin done_cnt++; done_at = k; end
        end
        check("b2b_wr_count", wr_seen, 8);
        check("b2b_done_count", done_cnt, 1);
        check("b2b_done_after_last_wr", done_at - last_wr_at, 1);

        // Gap pattern 1,0,1 reproduced on the write side.
        step(1, 0, 0, 8'd20, 8'd21);
        step(0, 0, 0, '0, '0);
        step(1, 1, 0, 8'd22, 8'd23);
        idle(LAT - 2);
        check("gap_wr0", int'(wr_en), 1);
        step(0, 0, 0, '0, '0);
        check("gap_wr1", int'(wr_en), 0);
        step(0, 0, 0, '0, '0);
        check("gap_wr2", int'(wr_en), 1);
        step(0, 0, 0, '0, '0);
        check("gap_done", int'(map_done), 1);
        idle(2);

        // Flush with three pairs in flight, then a normal stage.
        step(1, 0, 0, 8'd30, 8'd31);
        step(1, 0, 0, 8'd32, 8'd33);
        step(1, 1, 0, 8'd34, 8'd35);
        step(0, 0, 1, '0, '0);
        wr_seen = 0; done_cnt = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            step(0, 0, 0, '0, '0);
            if (wr_en) wr_seen++;
            if (map_done) done_cnt++;
        end
        check("flush_no_wr", wr_seen, 0);
        check("flush_no_done", done_cnt, 0);
        step(1, 0, 0, 8'd40, 8'd41);
        step(1, 1, 0, 8'd42, 8'd43);
        done_cnt = 0;
        for (int i = 0; i < LAT + 6; i++) begin
            step(0, 0, 0, '0, '0);
            if (map_done) done_cnt++;
        end
        check("post_flush_done", done_cnt, 1);

        // Empty stage: in_done with nothing outstanding completes at once.
        step(0, 1, 0, '0, '0);
        check("empty_done", int'(map_done), 1);
        step(0, 0, 0, '0, '0);
        check("empty_done_pulse", int'(map_done), 0);

        // Asynchronous reset mid-stream.
        step(1, 0, 0, 8'd50, 8'd51);
        step(1, 1, 0, 8'd52, 8'd53);
        #2;
        rst = 1;
        #1;
        check("rst_rd_en", int'(rd_en), 0);
        check("rst_rd_b0", int'(rd_addr_b0), 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_map_done", int'(map_done), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        k++;
        done_cnt = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            step(0, 0, 0, '0, '0);
            if (map_done) done_cnt++;
        end
        check("rst_no_done", done_cnt, 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            r0 = DW'($urandom) & ~DW'(1);
            r1 = r0 | DW'(1);
            if ($urandom_range(0, 9) == 0) r1 = DW'($urandom);
            step(($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 49) == 0), r0, r1);
        end
        step(0, 1, 0, '0, '0);
        idle(LAT + 4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
